// File: rtl/access_pkg.sv
// Shared types and width helpers for the access door controller.
// Optional duress support is built when ACCESS_DURESS_EN is defined.
package access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } door_state_e;

  localparam int CODE_W_DEF      = 12;
  localparam int N_CODES_DEF     = 4;
  localparam int OPEN_CYCLES_DEF = 8;
  localparam int MAX_FAILS_DEF   = 3;
  localparam int LOCK_CYCLES_DEF = 16;

  function automatic int idx_w(input int n_codes);
    return (n_codes > 1) ? $clog2(n_codes) : 1;
  endfunction

  // Timer must hold the larger of the two reload values.
  function automatic int tmr_w(input int open_c, input int lock_c);
    int m;
    m = (open_c > lock_c) ? open_c : lock_c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int fail_w(input int max_fails);
    return $clog2(max_fails + 1);
  endfunction

endpackage

// File: rtl/access_door_controller_code_matcher.sv
// Combinational code table lookup: lowest enabled matching slot wins.
module code_matcher
  import access_pkg::*;
#(
  parameter int CODE_W  = CODE_W_DEF,
  parameter int N_CODES = N_CODES_DEF,
  parameter int IDX_W   = idx_w(N_CODES)
) (
  input  logic [CODE_W-1:0]         code,
  input  logic [N_CODES*CODE_W-1:0] code_table,
  input  logic [N_CODES-1:0]        code_en,
  output logic                      hit,
  output logic [IDX_W-1:0]          idx
);

  logic [N_CODES-1:0] slot_hit;

  for (genvar i = 0; i < N_CODES; i++) begin : g_slot
    assign slot_hit[i] = code_en[i] && (code_table[i*CODE_W +: CODE_W] == code);
  end

  // Scan from the top so the lowest matching index is the last written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_CODES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/access_door_controller.sv
// Door controller: code table match, timed open window, failure lockout.
// Define ACCESS_DURESS_EN to add the duress_code / duress_alert path.
module access_door_controller
  import access_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int N_CODES     = N_CODES_DEF,
  parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
  parameter int MAX_FAILS   = MAX_FAILS_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  localparam int IDX_W      = idx_w(N_CODES),
  localparam int FAIL_W     = fail_w(MAX_FAILS)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef ACCESS_DURESS_EN
  input  logic [CODE_W-1:0]         duress_code,
  output logic                      duress_alert,
`endif
  input  logic                      code_valid,
  input  logic [CODE_W-1:0]         code,
  input  logic [N_CODES*CODE_W-1:0] code_table,
  input  logic [N_CODES-1:0]        code_en,
  input  logic                      emergency,
  output logic                      door,
  output logic                      busy,
  output logic                      granted,
  output logic                      denied,
  output logic                      lockout,
  output logic [IDX_W-1:0]          user_idx,
  output logic [FAIL_W-1:0]         fail_cnt
);

  localparam int TMR_W = tmr_w(OPEN_CYCLES, LOCK_CYCLES);
  localparam logic [TMR_W-1:0]  OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);

  door_state_e       state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [FAIL_W-1:0] fail_d;
  logic [IDX_W-1:0]  idx_d;
  logic              granted_d, denied_d, busy_d, lockout_d;

  logic              tbl_hit;
  logic [IDX_W-1:0]  tbl_idx;
  logic              accept;
  logic [IDX_W-1:0]  accept_idx;

  code_matcher #(
    .CODE_W  (CODE_W),
    .N_CODES (N_CODES),
    .IDX_W   (IDX_W)
  ) u_match (
    .code       (code),
    .code_table (code_table),
    .code_en    (code_en),
    .hit        (tbl_hit),
    .idx        (tbl_idx)
  );

`ifdef ACCESS_DURESS_EN
  logic duress_hit, alert_d;
  assign duress_hit = (code == duress_code);
  // Duress looks like an ordinary grant on slot 0 to anyone watching the door.
  assign accept     = duress_hit | tbl_hit;
  assign accept_idx = duress_hit ? '0 : tbl_idx;
  assign alert_d    = duress_alert | ((state_q == IDLE) & code_valid & duress_hit);
`else
  assign accept     = tbl_hit;
  assign accept_idx = tbl_idx;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    fail_d    = fail_cnt;
    idx_d     = user_idx;
    granted_d = 1'b0;
    denied_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (code_valid) begin
          if (accept) begin
            state_d   = OPEN;
            timer_d   = OPEN_LOAD;
            fail_d    = '0;
            idx_d     = accept_idx;
            granted_d = 1'b1;
          end else begin
            denied_d = 1'b1;
            if (fail_cnt == FAIL_LAST) begin
              state_d = LOCKED;
              timer_d = LOCK_LOAD;
              fail_d  = '0;
            end else begin
              fail_d = fail_cnt + 1'b1;
            end
          end
        end
      end
      OPEN, LOCKED: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    lockout_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      fail_cnt <= '0;
      user_idx <= '0;
      granted  <= 1'b0;
      denied   <= 1'b0;
      busy     <= 1'b0;
      lockout  <= 1'b0;
`ifdef ACCESS_DURESS_EN
      duress_alert <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_cnt <= fail_d;
      user_idx <= idx_d;
      granted  <= granted_d;
      denied   <= denied_d;
      busy     <= busy_d;
      lockout  <= lockout_d;
`ifdef ACCESS_DURESS_EN
      duress_alert <= alert_d;
`endif
    end
  end

  // Emergency bypasses the FSM entirely.
  assign door = (state_q == OPEN) | emergency;

endmodule

// File: tb/tb_access_door_controller.sv
// Directed + randomized bench for access_door_controller against a remaining-cycles model.
module tb_access_door_controller;
  localparam int CODE_W = 12, N = 4, OPEN_C = 8, MAXF = 3, LOCK_C = 16;

  logic clk = 1'b0;
  logic rst, code_valid, emergency;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] slot [N];
  logic [N*CODE_W-1:0] code_table;
  logic [N-1:0] code_en;
  logic door, busy, granted, denied, lockout;
  logic [1:0] user_idx;
  logic [1:0] fail_cnt;
`ifdef ACCESS_DURESS_EN
  logic [CODE_W-1:0] duress_code;
  logic duress_alert;
`endif

  int checks = 0, errors = 0;
  int m_open, m_lock, m_fails, m_idx;
  bit m_g, m_d, m_alert;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_tbl
    assign code_table[i*CODE_W +: CODE_W] = slot[i];
  end

  access_door_controller dut (
    .clk(clk), .rst(rst),
`ifdef ACCESS_DURESS_EN
    .duress_code(duress_code), .duress_alert(duress_alert),
`endif
    .code_valid(code_valid), .code(code), .code_table(code_table), .code_en(code_en),
    .emergency(emergency), .door(door), .busy(busy), .granted(granted), .denied(denied),
    .lockout(lockout), .user_idx(user_idx), .fail_cnt(fail_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: door is open/locked for a count of remaining cycles; no state encoding.
  task automatic model_step();
    int hit;
    if (rst) begin
      m_open = 0; m_lock = 0; m_fails = 0; m_idx = 0; m_g = 0; m_d = 0; m_alert = 0;
    end else begin
      m_g = 0; m_d = 0;
      if (m_open > 0) m_open--;
      else if (m_lock > 0) m_lock--;
      else if (code_valid) begin
        hit = -1;
        for (int i = 0; i < N; i++)
          if (hit < 0 && code_en[i] && slot[i] == code) hit = i;
`ifdef ACCESS_DURESS_EN
        if (code == duress_code) begin hit = 0; m_alert = 1; end
`endif
        if (hit >= 0) begin
          m_g = 1; m_idx = hit; m_fails = 0; m_open = OPEN_C;
        end else begin
          m_d = 1;
          if (m_fails + 1 == MAXF) begin m_fails = 0; m_lock = LOCK_C; end
          else m_fails++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("door", door, 32'((m_open > 0) || emergency));
    chk("busy", busy, 32'((m_open > 0) || (m_lock > 0)));
    chk("granted", granted, 32'(m_g));
    chk("denied", denied, 32'(m_d));
    chk("lockout", lockout, 32'(m_lock > 0));
    chk("user_idx", user_idx, m_idx);
    chk("fail_cnt", fail_cnt, m_fails);
`ifdef ACCESS_DURESS_EN
    chk("duress_alert", duress_alert, 32'(m_alert));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic strobe(input logic [CODE_W-1:0] c);
    code_valid = 1'b1; code = c;
    tick();
    code_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; emergency = 1'b0; code = '0; code_en = 4'b1111;
    slot[0] = 12'd731; slot[1] = 12'd294; slot[2] = 12'd337; slot[3] = 12'd191;
`ifdef ACCESS_DURESS_EN
    duress_code = 12'd4095;
`endif
    m_open = 0; m_lock = 0; m_fails = 0; m_idx = 0; m_g = 0; m_d = 0; m_alert = 0;
    tick(); tick();
    chk("reset_door", door, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: grant slot 2, door held 8 cycles
    strobe(12'd337);
    chk("t1_granted", granted, 1);
    chk("t1_idx", user_idx, 2);
    repeat (7) tick();
    chk("t1_door_last", door, 1);
    tick();
    chk("t1_door_closed", door, 0);
    repeat (2) tick();

    // 2: three denials -> lockout, strobe ignored while locked
    strobe(12'd100); chk("t2_fail1", fail_cnt, 1); tick();
    strobe(12'd100); chk("t2_fail2", fail_cnt, 2); tick();
    strobe(12'd100); chk("t2_lock", lockout, 1); chk("t2_fail0", fail_cnt, 0);
    repeat (3) tick();
    strobe(12'd731); chk("t2_no_grant", granted, 0); chk("t2_door", door, 0);
    repeat (14) tick();

    // 3: two denials then grant clears the counter
    strobe(12'd100); tick();
    strobe(12'd100); tick();
    strobe(12'd191); chk("t3_idx", user_idx, 3); chk("t3_fail", fail_cnt, 0);
    repeat (9) tick();
    strobe(12'd100); chk("t3_fail1", fail_cnt, 1);
    tick();

    // 4: disabled slot, then lowest index priority
    code_en = 4'b1101;
    strobe(12'd294); chk("t4_denied", denied, 1);
    tick();
    slot[3] = 12'd731; code_en = 4'b1111;
    strobe(12'd731); chk("t4_idx", user_idx, 0);
    repeat (9) tick();

    // 5: emergency forces door; reset in the middle of OPEN
    emergency = 1'b1; #1;
    chk("t5_door_comb", door, 1);
    tick(); chk("t5_busy", busy, 0);
    strobe(12'd337);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_door", door, 1);
    emergency = 1'b0; #1;
    chk("t5_rst_door0", door, 0);
    tick();

`ifdef ACCESS_DURESS_EN
    // 6: duress grant with sticky alert
    duress_code = 12'd999;
    strobe(12'd999);
    chk("t6_idx", user_idx, 0); chk("t6_alert", duress_alert, 1);
    repeat (12) tick();
    chk("t6_alert_sticky", duress_alert, 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
`endif

    // Randomized traffic
    repeat (3000) begin
      code_valid = ($urandom_range(0, 2) == 0);
      code = ($urandom_range(0, 1) == 0) ? slot[$urandom_range(0, N-1)] : CODE_W'($urandom);
      emergency = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) code_en = N'($urandom);
      if ($urandom_range(0, 99) == 0) slot[$urandom_range(0, N-1)] = CODE_W'($urandom_range(0, 7));
`ifdef ACCESS_DURESS_EN
      if ($urandom_range(0, 29) == 0) duress_code = code;
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
